// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM encodings, stall bit index, bus width.
package if_fetch_pkg;

    localparam logic True_v  = 1'b1;
    localparam logic False_v = 1'b0;

    localparam int INST_BUS_W = 32;
    localparam int STALL_IF   = 4;

    localparam logic [2:0] IF_IDLE = 3'd0;
    localparam logic [2:0] IF_B0   = 3'd1;
    localparam logic [2:0] IF_B1   = 3'd2;
    localparam logic [2:0] IF_B2   = 3'd3;
    localparam logic [2:0] IF_B3   = 3'd4;
    localparam logic [2:0] IF_HOLD = 3'd5;

    // Byte lane being fetched in states IF_B0..IF_B3.
    function automatic logic [1:0] byte_sel(input logic [2:0] st);
        byte_sel = 2'(st - IF_B0);
    endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache; used by if_fetch only when ICACHE_EN is defined.
module if_icache #(
    parameter int LINES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic [31:0] rd_data,
    input  logic        fill_en,
    input  logic [31:0] fill_pc,
    input  logic [31:0] fill_data
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             unused_low_bits;

    assign rd_idx          = lookup_pc[IDX_W+1:2];
    assign wr_idx          = fill_pc[IDX_W+1:2];
    assign unused_low_bits = ^{lookup_pc[1:0], fill_pc[1:0]};

    assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == lookup_pc[31:IDX_W+2]);
    assign rd_data = data_mem[rd_idx];

    // Only the valid bits need reset; stale tags/data are masked by them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[wr_idx]  <= fill_pc[31:IDX_W+2];
            data_mem[wr_idx] <= fill_data;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC and assembles 32-bit words from four byte reads.
// Optional direct-mapped I-cache enabled by defining ICACHE_EN.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef ICACHE_EN
    , parameter int ICACHE_LINES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [4:0]            stall_cmd,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic                  if_stall_req,
    output logic [31:0]           pc_o,
    output logic [INST_BUS_W-1:0] inst_o,
    output logic                  inst_valid_o,
    output logic [2:0]            state_dbg
);
    // Memory handshake: mem_req/mem_addr are held stable until a cycle with
    // mem_ack=1 and rdy=1; that cycle's mem_rdata is the byte at mem_addr.

    logic [2:0]            state, state_nxt;
    logic [31:0]           pc, pc_nxt;
    logic [INST_BUS_W-1:0] buf_q, buf_nxt;
    logic                  hit_q, hit_nxt;
    logic                  enter_b0;
    logic                  req_nxt, valid_nxt;
    logic [31:0]           addr_nxt, pc_o_nxt;
    logic [INST_BUS_W-1:0] inst_nxt;
    logic [1:0]            bsel;
    logic                  lookup_hit;
    logic [31:0]           lookup_data;
    logic                  unused_inputs;

    assign unused_inputs = ^{stall_cmd[3:0], br_target[1:0]};
    assign bsel          = byte_sel(state);
    assign state_dbg     = state;

`ifdef ICACHE_EN
    logic fill_en;
    assign fill_en = rdy && !br_taken && (state == IF_B3) && mem_ack;

    if_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .lookup_pc(pc_nxt),
        .hit      (lookup_hit),
        .rd_data  (lookup_data),
        .fill_en  (fill_en),
        .fill_pc  (pc),
        .fill_data({mem_rdata, buf_q[23:0]})
    );
`else
    assign lookup_hit  = False_v;
    assign lookup_data = '0;
`endif

    // Next PC and whether a new word fetch starts; branch beats everything.
    always_comb begin
        pc_nxt   = pc;
        enter_b0 = False_v;
        if (br_taken) begin
            pc_nxt   = {br_target[31:2], 2'b00};
            enter_b0 = True_v;
        end else if (state == IF_IDLE) begin
            enter_b0 = True_v;
        end else if (state == IF_HOLD && !stall_cmd[STALL_IF]) begin
            pc_nxt   = pc + 32'd4;
            enter_b0 = True_v;
        end
    end

    always_comb begin
        state_nxt = state;
        buf_nxt   = buf_q;
        hit_nxt   = False_v;
        req_nxt   = mem_req;
        addr_nxt  = mem_addr;
        pc_o_nxt  = pc_o;
        inst_nxt  = inst_o;
        valid_nxt = inst_valid_o;
        if (enter_b0) begin
            // A cache hit skips the byte reads: no request, word parked in the buffer.
            state_nxt = IF_B0;
            addr_nxt  = pc_nxt;
            req_nxt   = !lookup_hit;
            hit_nxt   = lookup_hit;
            buf_nxt   = lookup_hit ? lookup_data : '0;
            valid_nxt = False_v;
        end else begin
            case (state)
                IF_B0, IF_B1, IF_B2, IF_B3: begin
                    if (state == IF_B0 && hit_q) begin
                        state_nxt = IF_HOLD;
                        inst_nxt  = buf_q;
                        pc_o_nxt  = pc;
                        valid_nxt = True_v;
                    end else if (mem_ack) begin
                        buf_nxt[{bsel, 3'b000} +: 8] = mem_rdata;
                        if (state == IF_B3) begin
                            state_nxt = IF_HOLD;
                            req_nxt   = False_v;
                            inst_nxt  = {mem_rdata, buf_q[23:0]};
                            pc_o_nxt  = pc;
                            valid_nxt = True_v;
                        end else begin
                            state_nxt = state + 3'd1;
                            addr_nxt  = pc + {30'd0, bsel} + 32'd1;
                        end
                    end
                end
                IF_HOLD: begin
                end
                default: begin
                    state_nxt = IF_IDLE;
                    req_nxt   = False_v;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IF_IDLE;
            pc           <= RESET_PC;
            buf_q        <= '0;
            hit_q        <= False_v;
            mem_req      <= False_v;
            mem_addr     <= '0;
            if_stall_req <= False_v;
            pc_o         <= '0;
            inst_o       <= '0;
            inst_valid_o <= False_v;
        end else if (rdy) begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            buf_q        <= buf_nxt;
            hit_q        <= hit_nxt;
            mem_req      <= req_nxt;
            mem_addr     <= addr_nxt;
            if_stall_req <= (state_nxt != IF_HOLD);
            pc_o         <= pc_o_nxt;
            inst_o       <= inst_nxt;
            inst_valid_o <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: byte assembly, ack stalls, hold, branch, reset, rdy, wrap (+ cache loop).
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [4:0]  stall_cmd;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        if_stall_req;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [2:0]  state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .stall_cmd   (stall_cmd),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .if_stall_req(if_stall_req),
        .pc_o        (pc_o),
        .inst_o      (inst_o),
        .inst_valid_o(inst_valid_o),
        .state_dbg   (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_byte(input logic [7:0] b);
        mem_ack   = 1'b1;
        mem_rdata = b;
        step();
    endtask

    initial begin
        rst       = 1'b0;
        rdy       = 1'b1;
        stall_cmd = 5'b00000;
        br_taken  = 1'b0;
        br_target = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;

        step();
        step();
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_addr",  mem_addr, 32'h0);
        chk("rst_stall", 32'(if_stall_req), 32'd0);
        chk("rst_pc_o",  pc_o, 32'h0);
        chk("rst_inst",  inst_o, 32'h0);
        chk("rst_valid", 32'(inst_valid_o), 32'd0);
        rst = 1'b1;

        // Word at 0: bytes 13 00 50 00, acked every cycle.
        step();
        chk("t1_b0_req",   32'(mem_req), 32'd1);
        chk("t1_b0_addr",  mem_addr, 32'h0);
        chk("t1_b0_stall", 32'(if_stall_req), 32'd1);
        ack_byte(8'h13);
        chk("t1_b1_addr", mem_addr, 32'h1);
        ack_byte(8'h00);
        chk("t1_b2_addr", mem_addr, 32'h2);
        ack_byte(8'h50);
        chk("t1_b3_addr", mem_addr, 32'h3);
        chk("t1_b3_valid", 32'(inst_valid_o), 32'd0);
        ack_byte(8'h00);
        chk("t1_inst",  inst_o, 32'h0050_0013);
        chk("t1_pc_o",  pc_o, 32'h0);
        chk("t1_valid", 32'(inst_valid_o), 32'd1);
        chk("t1_req",   32'(mem_req), 32'd0);
        chk("t1_stall", 32'(if_stall_req), 32'd0);

        // Hold the presented word for 4 cycles.
        mem_ack   = 1'b0;
        stall_cmd = 5'b10000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t3_inst",  inst_o, 32'h0050_0013);
            chk("t3_pc_o",  pc_o, 32'h0);
            chk("t3_valid", 32'(inst_valid_o), 32'd1);
            chk("t3_req",   32'(mem_req), 32'd0);
        end
        stall_cmd = 5'b00000;
        step();
        chk("t3_rel_addr",  mem_addr, 32'h4);
        chk("t3_rel_req",   32'(mem_req), 32'd1);
        chk("t3_rel_valid", 32'(inst_valid_o), 32'd0);

        // Word at 4 with ack withheld 3 cycles in B2.
        ack_byte(8'h93);
        chk("t2_b1_addr", mem_addr, 32'h5);
        ack_byte(8'h05);
        chk("t2_b2_addr", mem_addr, 32'h6);
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_wait_addr",  mem_addr, 32'h6);
            chk("t2_wait_stall", 32'(if_stall_req), 32'd1);
            chk("t2_wait_req",   32'(mem_req), 32'd1);
        end
        ack_byte(8'ha0);
        chk("t2_b3_addr", mem_addr, 32'h7);
        ack_byte(8'h00);
        chk("t2_inst", inst_o, 32'h00a0_0593);
        chk("t2_pc_o", pc_o, 32'h4);

        // Branch in B2 of the word at 8, colliding with an ack.
        mem_ack = 1'b0;
        step();
        chk("t4_b0_addr", mem_addr, 32'h8);
        ack_byte(8'h11);
        ack_byte(8'h22);
        chk("t4_b2_addr", mem_addr, 32'ha);
        br_taken  = 1'b1;
        br_target = 32'h0000_1003;
        ack_byte(8'h33);
        br_taken = 1'b0;
        chk("t4_br_addr",  mem_addr, 32'h1000);
        chk("t4_br_valid", 32'(inst_valid_o), 32'd0);
        chk("t4_br_req",   32'(mem_req), 32'd1);
        ack_byte(8'h01);
        chk("t4_b1_addr",  mem_addr, 32'h1001);
        chk("t4_b1_valid", 32'(inst_valid_o), 32'd0);
        ack_byte(8'h02);
        ack_byte(8'h03);
        ack_byte(8'h04);
        chk("t4_inst", inst_o, 32'h0403_0201);
        chk("t4_pc_o", pc_o, 32'h1000);

        // Asynchronous reset in the middle of B1.
        mem_ack = 1'b0;
        step();
        chk("t5_b0_addr", mem_addr, 32'h1004);
        ack_byte(8'h55);
        chk("t5_b1_addr", mem_addr, 32'h1005);
        mem_ack = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("t5_req",   32'(mem_req), 32'd0);
        chk("t5_addr",  mem_addr, 32'h0);
        chk("t5_stall", 32'(if_stall_req), 32'd0);
        chk("t5_valid", 32'(inst_valid_o), 32'd0);
        chk("t5_pc_o",  pc_o, 32'h0);
        chk("t5_inst",  inst_o, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        chk("t5_restart_addr", mem_addr, 32'h0);
        chk("t5_restart_req",  32'(mem_req), 32'd1);

        // rdy=0 freezes state; acks are ignored.
        rdy       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'hee;
        step();
        step();
        chk("rdy_addr", mem_addr, 32'h0);
        chk("rdy_req",  32'(mem_req), 32'd1);

        // Fetch across the top of the address space, then wrap to 0.
        rdy       = 1'b1;
        br_taken  = 1'b1;
        br_target = 32'hffff_ffff;
        step();
        br_taken = 1'b0;
        chk("wr_b0_addr", mem_addr, 32'hffff_fffc);
        ack_byte(8'haa);
        chk("wr_b1_addr", mem_addr, 32'hffff_fffd);
        ack_byte(8'hbb);
        ack_byte(8'hcc);
        chk("wr_b3_addr", mem_addr, 32'hffff_ffff);
        ack_byte(8'hdd);
        chk("wr_inst", inst_o, 32'hddcc_bbaa);
        chk("wr_pc_o", pc_o, 32'hffff_fffc);
        mem_ack = 1'b0;
        step();
        chk("wr_next_addr", mem_addr, 32'h0);
        chk("wr_next_req",  32'(mem_req), 32'd1);

`ifdef ICACHE_EN
        // Two-instruction loop at 0x0/0x4: second pass served from the cache.
        ack_byte(8'h11);
        ack_byte(8'h22);
        ack_byte(8'h33);
        ack_byte(8'h44);
        chk("c_w0_inst", inst_o, 32'h4433_2211);
        mem_ack = 1'b0;
        step();
        chk("c_w1_addr", mem_addr, 32'h4);
        ack_byte(8'h55);
        ack_byte(8'h66);
        ack_byte(8'h77);
        ack_byte(8'h88);
        chk("c_w1_inst", inst_o, 32'h8877_6655);
        mem_ack   = 1'b0;
        br_taken  = 1'b1;
        br_target = 32'h0;
        step();
        br_taken = 1'b0;
        chk("c_hit0_req",   32'(mem_req), 32'd0);
        chk("c_hit0_stall", 32'(if_stall_req), 32'd1);
        step();
        chk("c_hit0_valid", 32'(inst_valid_o), 32'd1);
        chk("c_hit0_inst",  inst_o, 32'h4433_2211);
        chk("c_hit0_pc_o",  pc_o, 32'h0);
        step();
        chk("c_hit1_req",   32'(mem_req), 32'd0);
        chk("c_hit1_valid", 32'(inst_valid_o), 32'd0);
        step();
        chk("c_hit1_valid2", 32'(inst_valid_o), 32'd1);
        chk("c_hit1_inst",   inst_o, 32'h8877_6655);
        chk("c_hit1_pc_o",   pc_o, 32'h4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
